l15_req_arbiter: RTL and testbench

Two-port request arbiter between a pair of L1.5 private caches and the shared L2 request channel. Serialises msg1 traffic so exactly one L1.5 transaction is outstanding at the L2 at any time, using round-robin tie-breaking and a watchdog timeout. Routes every L2 msg2 response or forward to the destination cache given by the L2. The msg3 channel bypasses this block.

---
 rtl/l15_req_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_l15_req_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l15_req_arbiter.sv
// Two-port L1.5 -> L2 msg1 arbiter with round-robin and watchdog.
// Routes L2 msg2 responses/forwards back to the addressed L1.5.
`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef MESI_WIDTH
`define MESI_WIDTH 2
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif
`ifndef MSG_TYPE_LOAD_REQ
`define MSG_TYPE_LOAD_REQ 8'd1
`endif
`ifndef MSG_TYPE_STORE_REQ
`define MSG_TYPE_STORE_REQ 8'd2
`endif
`ifndef MSG_TYPE_DATA_ACK
`define MSG_TYPE_DATA_ACK 8'd3
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd4
`endif

module l15_req_arbiter #(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`MSG_WIDTH-1:0]   req0_type,
    input  logic [`TAG_WIDTH-1:0]   req0_tag,
    input  logic [`DATA_WIDTH-1:0]  req0_data,
    input  logic [`MSG_WIDTH-1:0]   req1_type,
    input  logic [`TAG_WIDTH-1:0]   req1_tag,
    input  logic [`DATA_WIDTH-1:0]  req1_data,
    output logic [`MSG_WIDTH-1:0]   l2_msg1_type,
    output logic [`TAG_WIDTH-1:0]   l2_msg1_tag,
    output logic [`DATA_WIDTH-1:0]  l2_msg1_data,
    output logic                    l2_msg1_src,
    input  logic [`MSG_WIDTH-1:0]   l2_msg2_type,
    input  logic [`TAG_WIDTH-1:0]   l2_msg2_tag,
    input  logic [`DATA_WIDTH-1:0]  l2_msg2_data,
    input  logic [`MESI_WIDTH-1:0]  l2_mesi_send,
    input  logic                    l2_msg2_dst,
    output logic [`MSG_WIDTH-1:0]   c0_msg2_type,
    output logic [`TAG_WIDTH-1:0]   c0_msg2_tag,
    output logic [`DATA_WIDTH-1:0]  c0_msg2_data,
    output logic [`MESI_WIDTH-1:0]  c0_mesi_send,
    output logic [`MSG_WIDTH-1:0]   c1_msg2_type,
    output logic [`TAG_WIDTH-1:0]   c1_msg2_tag,
    output logic [`DATA_WIDTH-1:0]  c1_msg2_data,
    output logic [`MESI_WIDTH-1:0]  c1_mesi_send,
    output logic                    busy,
    output logic                    owner,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             rr_last;
    logic             act0;
    logic             act1;
    logic             grant_vld;
    logic             grant_id;
    logic             ack_hit;
    logic             expire;

    assign act0 = (req0_type == `MSG_TYPE_LOAD_REQ) ||
                  (req0_type == `MSG_TYPE_STORE_REQ);
    assign act1 = (req1_type == `MSG_TYPE_LOAD_REQ) ||
                  (req1_type == `MSG_TYPE_STORE_REQ);
    assign ack_hit = (l2_msg2_type == `MSG_TYPE_DATA_ACK) &&
                     (l2_msg2_dst == owner);
    assign expire = (cnt == CNT_W'(TIMEOUT - 1));
    assign busy = (state != IDLE);

    // Next-state and grant selection; a tie goes to the requester not served last.
    always_comb begin
        state_nx  = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        unique case (state)
            IDLE: begin
                if (act0 || act1) begin
                    grant_vld = 1'b1;
                    grant_id  = (act0 && act1) ? ~rr_last : act1;
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (ack_hit) begin
                    state_nx = DRAIN;
                end else if (expire) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Watchdog: counts unacknowledged WAIT cycles, flags a sticky abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else if (grant_vld) begin
            cnt <= '0;
        end else if ((state == WAIT) && !ack_hit) begin
            cnt <= cnt + 1'b1;
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Registered msg1 toward L2; type is a one-cycle pulse, tag/data hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l2_msg1_type <= `MSG_TYPE_EMPTY;
            l2_msg1_tag  <= '0;
            l2_msg1_data <= '0;
            l2_msg1_src  <= 1'b0;
            owner        <= 1'b0;
            rr_last      <= 1'b1;
        end else begin
            l2_msg1_type <= `MSG_TYPE_EMPTY;
            if (grant_vld) begin
                l2_msg1_type <= grant_id ? req1_type : req0_type;
                l2_msg1_tag  <= grant_id ? req1_tag : req0_tag;
                l2_msg1_data <= grant_id ? req1_data : req0_data;
                l2_msg1_src  <= grant_id;
                owner        <= grant_id;
                rr_last      <= grant_id;
            end
        end
    end

    // msg2 routing to the cache named by the L2, independent of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c0_msg2_type <= `MSG_TYPE_EMPTY;
            c0_msg2_tag  <= '0;
            c0_msg2_data <= '0;
            c0_mesi_send <= '0;
            c1_msg2_type <= `MSG_TYPE_EMPTY;
            c1_msg2_tag  <= '0;
            c1_msg2_data <= '0;
            c1_mesi_send <= '0;
        end else begin
            c0_msg2_type <= `MSG_TYPE_EMPTY;
            c1_msg2_type <= `MSG_TYPE_EMPTY;
            if (l2_msg2_type != `MSG_TYPE_EMPTY) begin
                if (l2_msg2_dst) begin
                    c1_msg2_type <= l2_msg2_type;
                    c1_msg2_tag  <= l2_msg2_tag;
                    c1_msg2_data <= l2_msg2_data;
                    c1_mesi_send <= l2_mesi_send;
                end else begin
                    c0_msg2_type <= l2_msg2_type;
                    c0_msg2_tag  <= l2_msg2_tag;
                    c0_msg2_data <= l2_msg2_data;
                    c0_mesi_send <= l2_mesi_send;
                end
            end
        end
    end

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Bench for l15_req_arbiter: scoreboard on l2_msg1 and c*_msg2,
// direct checks on busy/owner/timeout_err and reset behaviour.
`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef MESI_WIDTH
`define MESI_WIDTH 2
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif
`ifndef MSG_TYPE_LOAD_REQ
`define MSG_TYPE_LOAD_REQ 8'd1
`endif
`ifndef MSG_TYPE_STORE_REQ
`define MSG_TYPE_STORE_REQ 8'd2
`endif
`ifndef MSG_TYPE_DATA_ACK
`define MSG_TYPE_DATA_ACK 8'd3
`endif
`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd4
`endif

module tb_l15_req_arbiter;

    localparam logic [1:0] MESI_E = 2'd2;

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  tag;
        logic [63:0] data;
        logic [1:0]  aux;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [7:0]  req0_type, req0_tag, req1_type, req1_tag;
    logic [63:0] req0_data, req1_data;
    logic [7:0]  l2_msg1_type, l2_msg1_tag;
    logic [63:0] l2_msg1_data;
    logic        l2_msg1_src;
    logic [7:0]  l2_msg2_type, l2_msg2_tag;
    logic [63:0] l2_msg2_data;
    logic [1:0]  l2_mesi_send;
    logic        l2_msg2_dst;
    logic [7:0]  c0_msg2_type, c0_msg2_tag, c1_msg2_type, c1_msg2_tag;
    logic [63:0] c0_msg2_data, c1_msg2_data;
    logic [1:0]  c0_mesi_send, c1_mesi_send;
    logic        busy, owner, timeout_err;

    int   checks = 0;
    int   errors = 0;
    ent_t l2_q[$];
    ent_t c0_q[$];
    ent_t c1_q[$];

    l15_req_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_type(req0_type), .req0_tag(req0_tag), .req0_data(req0_data),
        .req1_type(req1_type), .req1_tag(req1_tag), .req1_data(req1_data),
        .l2_msg1_type(l2_msg1_type), .l2_msg1_tag(l2_msg1_tag),
        .l2_msg1_data(l2_msg1_data), .l2_msg1_src(l2_msg1_src),
        .l2_msg2_type(l2_msg2_type), .l2_msg2_tag(l2_msg2_tag),
        .l2_msg2_data(l2_msg2_data), .l2_mesi_send(l2_mesi_send),
        .l2_msg2_dst(l2_msg2_dst),
        .c0_msg2_type(c0_msg2_type), .c0_msg2_tag(c0_msg2_tag),
        .c0_msg2_data(c0_msg2_data), .c0_mesi_send(c0_mesi_send),
        .c1_msg2_type(c1_msg2_type), .c1_msg2_tag(c1_msg2_tag),
        .c1_msg2_data(c1_msg2_data), .c1_mesi_send(c1_mesi_send),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every valid output pulse must match the queue head.
    always @(negedge clk) begin
        ent_t e;
        if (l2_msg1_type != `MSG_TYPE_EMPTY) begin
            if (l2_q.size() == 0) begin
                chk("l2_extra", 64'(l2_msg1_type), 64'(0));
            end else begin
                e = l2_q.pop_front();
                chk("l2_type", 64'(l2_msg1_type), 64'(e.typ));
                chk("l2_tag", 64'(l2_msg1_tag), 64'(e.tag));
                chk("l2_data", l2_msg1_data, e.data);
                chk("l2_src", 64'(l2_msg1_src), 64'(e.aux[0]));
            end
        end
        if (c0_msg2_type != `MSG_TYPE_EMPTY) begin
            if (c0_q.size() == 0) begin
                chk("c0_extra", 64'(c0_msg2_type), 64'(0));
            end else begin
                e = c0_q.pop_front();
                chk("c0_type", 64'(c0_msg2_type), 64'(e.typ));
                chk("c0_tag", 64'(c0_msg2_tag), 64'(e.tag));
                chk("c0_data", c0_msg2_data, e.data);
                chk("c0_mesi", 64'(c0_mesi_send), 64'(e.aux));
            end
        end
        if (c1_msg2_type != `MSG_TYPE_EMPTY) begin
            if (c1_q.size() == 0) begin
                chk("c1_extra", 64'(c1_msg2_type), 64'(0));
            end else begin
                e = c1_q.pop_front();
                chk("c1_type", 64'(c1_msg2_type), 64'(e.typ));
                chk("c1_tag", 64'(c1_msg2_tag), 64'(e.tag));
                chk("c1_data", c1_msg2_data, e.data);
                chk("c1_mesi", 64'(c1_mesi_send), 64'(e.aux));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic who, input logic [7:0] t,
                           input logic [7:0] tg, input logic [63:0] d);
        if (who) begin
            req1_type = t; req1_tag = tg; req1_data = d;
        end else begin
            req0_type = t; req0_tag = tg; req0_data = d;
        end
    endtask

    task automatic exp_l2(input logic [7:0] t, input logic [7:0] tg,
                          input logic [63:0] d, input logic src);
        l2_q.push_back('{typ: t, tag: tg, data: d, aux: {1'b0, src}});
    endtask

    task automatic send_msg2(input logic [7:0] t, input logic dst,
                             input logic [7:0] tg, input logic [63:0] d,
                             input logic [1:0] m);
        ent_t e;
        e = '{typ: t, tag: tg, data: d, aux: m};
        if (dst) c1_q.push_back(e);
        else c0_q.push_back(e);
        l2_msg2_type = t; l2_msg2_dst = dst;
        l2_msg2_tag = tg; l2_msg2_data = d; l2_mesi_send = m;
        cyc();
        l2_msg2_type = `MSG_TYPE_EMPTY;
    endtask

    task automatic serve(input logic who, input logic [63:0] d);
        set_req(who, `MSG_TYPE_EMPTY, 8'h0, 64'h0);
        send_msg2(`MSG_TYPE_DATA_ACK, who, 8'h0, d, MESI_E);
    endtask

    task automatic wait_grant(input logic src, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (l2_msg1_type == `MSG_TYPE_EMPTY && n < 20);
        chk("grant_seen", 64'(l2_msg1_type != `MSG_TYPE_EMPTY), 64'(1));
        chk("owner", 64'(owner), 64'(src));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_l2t"}, 64'(l2_msg1_type), 64'(0));
        chk({tag, "_l2tag"}, 64'(l2_msg1_tag), 64'(0));
        chk({tag, "_l2d"}, l2_msg1_data, 64'(0));
        chk({tag, "_src"}, 64'(l2_msg1_src), 64'(0));
        chk({tag, "_c0"}, 64'({c0_msg2_type, c0_msg2_tag, c0_mesi_send}), 64'(0));
        chk({tag, "_c0d"}, c0_msg2_data, 64'(0));
        chk({tag, "_c1"}, 64'({c1_msg2_type, c1_msg2_tag, c1_mesi_send}), 64'(0));
        chk({tag, "_c1d"}, c1_msg2_data, 64'(0));
        chk({tag, "_flags"}, 64'({busy, owner, timeout_err}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        req0_type = `MSG_TYPE_EMPTY; req0_tag = '0; req0_data = '0;
        req1_type = `MSG_TYPE_EMPTY; req1_tag = '0; req1_data = '0;
        l2_msg2_type = `MSG_TYPE_EMPTY; l2_msg2_tag = '0;
        l2_msg2_data = '0; l2_mesi_send = '0; l2_msg2_dst = 1'b0;
        #2;
        chk_all_zero("rst");
        cyc();
        rst = 1'b1;
        cyc();

        // Single load from cache 0.
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'h3, 64'h11);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h3, 64'h11, 1'b0);
        wait_grant(1'b0, n);
        chk("load_lat", 64'(n), 64'(1));
        chk("load_busy", 64'(busy), 64'(1));
        serve(1'b0, 64'hA5);
        chk("drain_busy", 64'(busy), 64'(1));
        cyc();
        chk("idle_busy", 64'(busy), 64'(0));

        // Tie after reset: 0 first, then 1; fresh tie goes to 0 again.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'h1, 64'h100);
        set_req(1'b1, `MSG_TYPE_LOAD_REQ, 8'h2, 64'h200);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h1, 64'h100, 1'b0);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h2, 64'h200, 1'b1);
        wait_grant(1'b0, n);
        serve(1'b0, 64'h1);
        wait_grant(1'b1, n);
        chk("next_grant_lat", 64'(n), 64'(2));
        serve(1'b1, 64'h2);
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'h21, 64'h300);
        set_req(1'b1, `MSG_TYPE_LOAD_REQ, 8'h22, 64'h400);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h21, 64'h300, 1'b0);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h22, 64'h400, 1'b1);
        wait_grant(1'b0, n);
        serve(1'b0, 64'h3);
        wait_grant(1'b1, n);
        serve(1'b1, 64'h4);
        cyc();

        // Store pass-through from cache 1.
        set_req(1'b1, `MSG_TYPE_STORE_REQ, 8'h5, 64'h5A);
        exp_l2(`MSG_TYPE_STORE_REQ, 8'h5, 64'h5A, 1'b1);
        wait_grant(1'b1, n);
        chk("store_lat", 64'(n), 64'(1));
        serve(1'b1, 64'h0);
        cyc();

        // DATA_ACK in IDLE is routed but leaves the arbiter idle.
        send_msg2(`MSG_TYPE_DATA_ACK, 1'b0, 8'h6, 64'h66, MESI_E);
        chk("idle_ack_busy", 64'(busy), 64'(0));
        cyc();
        chk("idle_ack_busy2", 64'(busy), 64'(0));

        // Forward and mismatched ack while owner 0 waits.
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'h7, 64'h77);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h7, 64'h77, 1'b0);
        wait_grant(1'b0, n);
        send_msg2(`MSG_TYPE_INV_FWD, 1'b1, 8'h8, 64'h88, 2'd0);
        chk("fwd_busy", 64'(busy), 64'(1));
        send_msg2(`MSG_TYPE_DATA_ACK, 1'b1, 8'h9, 64'h99, MESI_E);
        cyc();
        chk("mis_ack_busy", 64'(busy), 64'(1));
        chk("mis_ack_owner", 64'(owner), 64'(0));
        serve(1'b0, 64'h77);
        cyc();
        chk("no_tmo_yet", 64'(timeout_err), 64'(0));

        // Watchdog abort and re-grant.
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'h9, 64'h999);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h9, 64'h999, 1'b0);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'h9, 64'h999, 1'b0);
        wait_grant(1'b0, n);
        repeat (3) cyc();
        chk("tmo_early", 64'(timeout_err), 64'(0));
        cyc();
        chk("tmo_set", 64'(timeout_err), 64'(1));
        cyc();
        chk("reissue", 64'(l2_msg1_type), 64'(`MSG_TYPE_LOAD_REQ));
        serve(1'b0, 64'h5);
        cyc();
        chk("tmo_sticky", 64'(timeout_err), 64'(1));

        // Async reset mid-WAIT, between clock edges.
        set_req(1'b0, `MSG_TYPE_LOAD_REQ, 8'hC, 64'hCC);
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'hC, 64'hCC, 1'b0);
        wait_grant(1'b0, n);
        send_msg2(`MSG_TYPE_INV_FWD, 1'b0, 8'hD, 64'hDD, 2'd1);
        #5;
        rst = 1'b0;
        #1;
        chk_all_zero("arst");
        cyc();
        cyc();
        chk("arst_hold_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        exp_l2(`MSG_TYPE_LOAD_REQ, 8'hC, 64'hCC, 1'b0);
        wait_grant(1'b0, n);
        chk("post_rst_lat", 64'(n), 64'(1));
        serve(1'b0, 64'hE);
        repeat (3) cyc();

        chk("sb_l2_left", 64'(l2_q.size()), 64'(0));
        chk("sb_c0_left", 64'(c0_q.size()), 64'(0));
        chk("sb_c1_left", 64'(c1_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
